// File: rtl/relay_guard_multi.sv
// Multi-channel sensor-deviation guard: per-channel trip / retry-wait / lockout FSM driving one relay each.
// Build macro RELAY_GUARD_DEBOUNCE_EN adds a DEB_N-sample fail debounce in MONITOR (default: single-sample trip).
module relay_guard_multi #(
  parameter int N_CH        = 4,
  parameter int SEN_W       = 10,
  parameter int WAIT_TICKS  = 312,
  parameter int MAX_RETRY   = 3,
  parameter int CLEAR_TICKS = 625,
  parameter int DEB_N       = 3
) (
  input  logic                    clk_16ms,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_CH*SEN_W-1:0]   sen,
  input  logic [N_CH*SEN_W-1:0]   sen_ref,
  input  logic [SEN_W-1:0]        threshold,
  input  logic [N_CH-1:0]         clr_lockout,
  output logic [N_CH-1:0]         relay_out,
  output logic [N_CH-1:0]         lockout,
  output logic [N_CH*4-1:0]       retry_cnt,
  output logic                    any_fault
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MONITOR = 3'd1;
  localparam logic [2:0] ST_TRIP    = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam int WT_W = $clog2(WAIT_TICKS + 1);
  localparam int HC_W = $clog2(CLEAR_TICKS + 1);

  localparam logic [WT_W-1:0] WAIT_LAST  = WT_W'(WAIT_TICKS - 1);
  localparam logic [WT_W-1:0] WT_ONE     = WT_W'(1);
  localparam logic [HC_W-1:0] CLEAR_LAST = HC_W'(CLEAR_TICKS - 1);
  localparam logic [HC_W-1:0] CLEAR_TOP  = HC_W'(CLEAR_TICKS);
  localparam logic [HC_W-1:0] HC_ONE     = HC_W'(1);
  localparam logic [3:0]      RETRY_MAX  = 4'(MAX_RETRY);

  function automatic logic [SEN_W-1:0] abs_diff(input logic [SEN_W-1:0] a,
                                                input logic [SEN_W-1:0] b);
    if (a >= b) return a - b;
    else        return b - a;
  endfunction

  logic [N_CH-1:0] relay_nxt_vec_s;
  logic            any_fault_r;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [2:0]       state_r, state_nxt_s;
      logic [WT_W-1:0]  wait_tmr_r, wait_nxt_s;
      logic [HC_W-1:0]  healthy_r, healthy_nxt_s;
      logic [3:0]       retry_r, retry_nxt_s;
      logic             relay_r, relay_nxt_s;
      logic             lock_r, lock_nxt_s;
      logic [SEN_W-1:0] diff_s;
      logic             fail_s;
      logic             trip_req_s;

      assign diff_s = abs_diff(sen[gi*SEN_W +: SEN_W], sen_ref[gi*SEN_W +: SEN_W]);
      assign fail_s = (diff_s > threshold);

`ifdef RELAY_GUARD_DEBOUNCE_EN
      localparam int DB_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;
      localparam logic [DB_W-1:0] DEB_LAST = DB_W'(DEB_N - 1);
      localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
      logic [DB_W-1:0] deb_r;

      assign trip_req_s = fail_s && (deb_r == DEB_LAST);

      // Consecutive-fail counter; any non-MONITOR cycle or healthy sample zeroes it.
      always_ff @(posedge clk_16ms or posedge rst) begin
        if (rst) begin
          deb_r <= '0;
        end else if ((state_r == ST_MONITOR) && enable && fail_s && !trip_req_s) begin
          deb_r <= deb_r + DB_ONE;
        end else begin
          deb_r <= '0;
        end
      end
`else
      // DEB_N only matters to the debounced build; any legal value (>=1) leaves this a plain fail.
      assign trip_req_s = fail_s & (DEB_N > 0);
`endif

      // Next-state and next-output computation for this channel.
      always_comb begin
        state_nxt_s   = state_r;
        relay_nxt_s   = relay_r;
        lock_nxt_s    = lock_r;
        retry_nxt_s   = retry_r;
        wait_nxt_s    = wait_tmr_r;
        healthy_nxt_s = healthy_r;
        case (state_r)
          ST_IDLE: begin
            relay_nxt_s   = 1'b0;
            lock_nxt_s    = 1'b0;
            wait_nxt_s    = '0;
            healthy_nxt_s = '0;
            if (enable) state_nxt_s = ST_MONITOR;
            else        state_nxt_s = ST_IDLE;
          end
          ST_MONITOR: begin
            if (!enable) begin
              state_nxt_s   = ST_IDLE;
              relay_nxt_s   = 1'b0;
              wait_nxt_s    = '0;
              healthy_nxt_s = '0;
            end else if (trip_req_s) begin
              state_nxt_s   = ST_TRIP;
              relay_nxt_s   = 1'b1;
              wait_nxt_s    = '0;
              healthy_nxt_s = '0;
              if (retry_r != 4'hF) retry_nxt_s = retry_r + 4'd1;
              else                 retry_nxt_s = retry_r;
            end else if (fail_s) begin
              healthy_nxt_s = '0;
            end else if (healthy_r >= CLEAR_LAST) begin
              // Long healthy run forgives earlier trips; counter parks at the top.
              healthy_nxt_s = CLEAR_TOP;
              retry_nxt_s   = 4'd0;
            end else begin
              healthy_nxt_s = healthy_r + HC_ONE;
            end
          end
          ST_TRIP: begin
            if (!enable) begin
              state_nxt_s = ST_IDLE;
              relay_nxt_s = 1'b0;
              wait_nxt_s  = '0;
            end else begin
              state_nxt_s = ST_WAIT;
              relay_nxt_s = 1'b1;
              wait_nxt_s  = '0;
            end
          end
          ST_WAIT: begin
            if (!enable) begin
              state_nxt_s = ST_IDLE;
              relay_nxt_s = 1'b0;
              wait_nxt_s  = '0;
            end else if (wait_tmr_r == WAIT_LAST) begin
              wait_nxt_s = '0;
              if (retry_r == RETRY_MAX) begin
                state_nxt_s = ST_LOCKOUT;
                relay_nxt_s = 1'b1;
                lock_nxt_s  = 1'b1;
              end else begin
                state_nxt_s   = ST_MONITOR;
                relay_nxt_s   = 1'b0;
                healthy_nxt_s = '0;
              end
            end else begin
              wait_nxt_s = wait_tmr_r + WT_ONE;
            end
          end
          ST_LOCKOUT: begin
            if (clr_lockout[gi]) begin
              state_nxt_s = ST_IDLE;
              relay_nxt_s = 1'b0;
              lock_nxt_s  = 1'b0;
              retry_nxt_s = 4'd0;
            end else begin
              state_nxt_s = ST_LOCKOUT;
              relay_nxt_s = 1'b1;
              lock_nxt_s  = 1'b1;
            end
          end
          default: begin
            state_nxt_s   = ST_IDLE;
            relay_nxt_s   = 1'b0;
            lock_nxt_s    = 1'b0;
            wait_nxt_s    = '0;
            healthy_nxt_s = '0;
          end
        endcase
      end

      // Channel state and output registers.
      always_ff @(posedge clk_16ms or posedge rst) begin
        if (rst) begin
          state_r    <= ST_IDLE;
          relay_r    <= 1'b0;
          lock_r     <= 1'b0;
          retry_r    <= 4'd0;
          wait_tmr_r <= '0;
          healthy_r  <= '0;
        end else begin
          state_r    <= state_nxt_s;
          relay_r    <= relay_nxt_s;
          lock_r     <= lock_nxt_s;
          retry_r    <= retry_nxt_s;
          wait_tmr_r <= wait_nxt_s;
          healthy_r  <= healthy_nxt_s;
        end
      end

      assign relay_nxt_vec_s[gi]   = relay_nxt_s;
      assign relay_out[gi]         = relay_r;
      assign lockout[gi]           = lock_r;
      assign retry_cnt[gi*4 +: 4]  = retry_r;
    end
  endgenerate

  // Summary fault flag registered from next relay values so it tracks relay_out exactly.
  always_ff @(posedge clk_16ms or posedge rst) begin
    if (rst) any_fault_r <= 1'b0;
    else     any_fault_r <= |relay_nxt_vec_s;
  end

  assign any_fault = any_fault_r;

endmodule

// File: tb/tb_relay_guard_multi.sv
// Directed self-checking bench for relay_guard_multi (default build, no debounce).
module tb_relay_guard_multi;
  localparam int N_CH  = 4;
  localparam int SEN_W = 10;

  logic                  clk_16ms = 1'b0;
  logic                  rst;
  logic                  enable;
  logic [N_CH*SEN_W-1:0] sen;
  logic [N_CH*SEN_W-1:0] sen_ref;
  logic [SEN_W-1:0]      threshold;
  logic [N_CH-1:0]       clr_lockout;
  logic [N_CH-1:0]       relay_out;
  logic [N_CH-1:0]       lockout;
  logic [N_CH*4-1:0]     retry_cnt;
  logic                  any_fault;

  int errors = 0;
  int checks = 0;

  relay_guard_multi dut (
    .clk_16ms    (clk_16ms),
    .rst         (rst),
    .enable      (enable),
    .sen         (sen),
    .sen_ref     (sen_ref),
    .threshold   (threshold),
    .clr_lockout (clr_lockout),
    .relay_out   (relay_out),
    .lockout     (lockout),
    .retry_cnt   (retry_cnt),
    .any_fault   (any_fault)
  );

  always #5 clk_16ms = ~clk_16ms;

  task automatic step(input int n);
    repeat (n) @(negedge clk_16ms);
  endtask

  task automatic set_ch(input int ch, input logic [SEN_W-1:0] s, input logic [SEN_W-1:0] r);
    sen[ch*SEN_W +: SEN_W]     = s;
    sen_ref[ch*SEN_W +: SEN_W] = r;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; threshold = 10'd20; clr_lockout = 4'b0000;
    for (int c = 0; c < N_CH; c++) set_ch(c, 10'd500, 10'd500);
    step(3);
    checks++; if (relay_out !== 4'b0000) begin errors++; $display("FAIL reset_relay: got %b want %b", relay_out, 4'b0000); end
    checks++; if (lockout !== 4'b0000) begin errors++; $display("FAIL reset_lockout: got %b want %b", lockout, 4'b0000); end
    checks++; if (retry_cnt !== 16'h0000) begin errors++; $display("FAIL reset_retry: got %h want %h", retry_cnt, 16'h0000); end
    checks++; if (any_fault !== 1'b0) begin errors++; $display("FAIL reset_any_fault: got %b want %b", any_fault, 1'b0); end
    rst = 1'b0;
  endtask

  task automatic test_monitor_steady;
    enable = 1'b1;
    step(1000);
    checks++; if (relay_out !== 4'b0000) begin errors++; $display("FAIL steady_relay: got %b want %b", relay_out, 4'b0000); end
    checks++; if (retry_cnt !== 16'h0000) begin errors++; $display("FAIL steady_retry: got %h want %h", retry_cnt, 16'h0000); end
    checks++; if (any_fault !== 1'b0) begin errors++; $display("FAIL steady_any_fault: got %b want %b", any_fault, 1'b0); end
  endtask

  task automatic test_single_trip_and_clear;
    set_ch(1, 10'd530, 10'd500);
    step(1);
    set_ch(1, 10'd500, 10'd500);
    checks++; if (relay_out !== 4'b0010) begin errors++; $display("FAIL trip_relay_rise: got %b want %b", relay_out, 4'b0010); end
    checks++; if (retry_cnt !== 16'h0010) begin errors++; $display("FAIL trip_retry: got %h want %h", retry_cnt, 16'h0010); end
    checks++; if (any_fault !== 1'b1) begin errors++; $display("FAIL trip_any_fault: got %b want %b", any_fault, 1'b1); end
    step(312);
    checks++; if (relay_out !== 4'b0010) begin errors++; $display("FAIL trip_hold_313: got %b want %b", relay_out, 4'b0010); end
    step(1);
    checks++; if (relay_out !== 4'b0000) begin errors++; $display("FAIL trip_release: got %b want %b", relay_out, 4'b0000); end
    checks++; if (any_fault !== 1'b0) begin errors++; $display("FAIL release_any_fault: got %b want %b", any_fault, 1'b0); end
    step(624);
    checks++; if (retry_cnt !== 16'h0010) begin errors++; $display("FAIL clear_early: got %h want %h", retry_cnt, 16'h0010); end
    step(1);
    checks++; if (retry_cnt !== 16'h0000) begin errors++; $display("FAIL clear_at_625: got %h want %h", retry_cnt, 16'h0000); end
  endtask

  task automatic test_lockout;
    set_ch(2, 10'd600, 10'd500);
    step(1);
    checks++; if (retry_cnt !== 16'h0100) begin errors++; $display("FAIL lock_trip1: got %h want %h", retry_cnt, 16'h0100); end
    step(313);
    checks++; if (relay_out !== 4'b0000) begin errors++; $display("FAIL lock_gap1: got %b want %b", relay_out, 4'b0000); end
    step(1);
    checks++; if (retry_cnt !== 16'h0200) begin errors++; $display("FAIL lock_trip2: got %h want %h", retry_cnt, 16'h0200); end
    step(314);
    checks++; if (retry_cnt !== 16'h0300 || relay_out !== 4'b0100) begin errors++; $display("FAIL lock_trip3: got %h/%b want %h/%b", retry_cnt, relay_out, 16'h0300, 4'b0100); end
    step(313);
    checks++; if (lockout !== 4'b0100 || relay_out !== 4'b0100) begin errors++; $display("FAIL lock_enter: got %b/%b want %b/%b", lockout, relay_out, 4'b0100, 4'b0100); end
    enable = 1'b0;
    step(5);
    checks++; if (lockout !== 4'b0100 || relay_out !== 4'b0100) begin errors++; $display("FAIL lock_enable_ignored: got %b/%b want %b/%b", lockout, relay_out, 4'b0100, 4'b0100); end
    enable = 1'b1;
    step(2);
    set_ch(2, 10'd500, 10'd500);
    clr_lockout = 4'b0100;
    step(1);
    clr_lockout = 4'b0000;
    checks++; if (lockout !== 4'b0000 || relay_out !== 4'b0000 || retry_cnt !== 16'h0000) begin errors++; $display("FAIL lock_clear: got %b/%b/%h want 0000/0000/0000", lockout, relay_out, retry_cnt); end
    set_ch(2, 10'd600, 10'd500);
    step(1);
    checks++; if (relay_out !== 4'b0000) begin errors++; $display("FAIL idle_ignores_fail: got %b want %b", relay_out, 4'b0000); end
    step(1);
    checks++; if (relay_out !== 4'b0100) begin errors++; $display("FAIL monitor_after_clear: got %b want %b", relay_out, 4'b0100); end
    step(10);
    enable = 1'b0;
    step(1);
    checks++; if (relay_out !== 4'b0000 || retry_cnt !== 16'h0100) begin errors++; $display("FAIL enable_low_wait: got %b/%h want %b/%h", relay_out, retry_cnt, 4'b0000, 16'h0100); end
    set_ch(2, 10'd500, 10'd500);
    enable = 1'b1;
    step(2);
  endtask

  task automatic test_threshold;
    set_ch(3, 10'd520, 10'd500);
    step(5);
    checks++; if (relay_out !== 4'b0000) begin errors++; $display("FAIL thr_equal_high: got %b want %b", relay_out, 4'b0000); end
    set_ch(3, 10'd480, 10'd500);
    step(3);
    checks++; if (relay_out !== 4'b0000) begin errors++; $display("FAIL thr_equal_low: got %b want %b", relay_out, 4'b0000); end
    threshold = 10'd19;
    step(1);
    checks++; if (relay_out !== 4'b1000 || retry_cnt !== 16'h1100) begin errors++; $display("FAIL thr_abs_trip: got %b/%h want %b/%h", relay_out, retry_cnt, 4'b1000, 16'h1100); end
    threshold = 10'd20;
    set_ch(3, 10'd500, 10'd500);
  endtask

  task automatic test_reset_mid_wait;
    step(20);
    rst = 1'b1;
    #1;
    checks++; if (relay_out !== 4'b0000 || retry_cnt !== 16'h0000 || any_fault !== 1'b0) begin errors++; $display("FAIL async_reset_wait: got %b/%h/%b want 0000/0000/0", relay_out, retry_cnt, any_fault); end
    step(2);
    rst = 1'b0;
    step(3);
  endtask

  task automatic test_enable_wins;
    set_ch(0, 10'd900, 10'd500);
    enable = 1'b0;
    step(1);
    checks++; if (relay_out !== 4'b0000 || retry_cnt !== 16'h0000) begin errors++; $display("FAIL enable_wins: got %b/%h want %b/%h", relay_out, retry_cnt, 4'b0000, 16'h0000); end
    set_ch(0, 10'd500, 10'd500);
    enable = 1'b1;
    step(3);
    checks++; if (relay_out !== 4'b0000) begin errors++; $display("FAIL rearm_healthy: got %b want %b", relay_out, 4'b0000); end
  endtask

  initial begin
    test_reset;
    test_monitor_steady;
    test_single_trip_and_clear;
    test_lockout;
    test_threshold;
    test_reset_mid_wait;
    test_enable_wins;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
